main_mem_responder: RTL
=======================

Name: main_mem_responder

Overview:
- Memory-side responder for the direct-mapped cache's refill and write-back traffic. It serves whole-line reads and writes over a word-wide burst interface.
- Backs the full MEMORY_SIZE (64kB) address space as 16384 words of WORD_SIZE bits, with a programmable access latency.
- Sits below the cache controller and is the far end of its line-fill/evict interface. It is also the reference memory model in block-level benches.

Parameters:
- READ_LATENCY, 8, cycles from read request accept to first read beat minus one; legal range 1..255.
- WRITE_LATENCY, 4, cycles from last write beat accept to commit and wr_done; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  line request valid
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = write-back line, 0 = refill read
- req_line_addr  in  LINE_ADDR_LENGTH (12)  line address, which is {tag,index}
- wdata_valid  in  1  write beat valid
- wdata  in  WORD_SIZE  write beat data
- wdata_ready  out  1  write beat accepted when high together with wdata_valid
- rdata_valid  out  1  read beat valid
- rdata  out  WORD_SIZE  read beat data
- rdata_last  out  1  marks final beat (beat BEATS_PER_LINE-1)
- rdata_ready  in  1  consumer accepts read beat
- wr_done  out  1  one-cycle pulse when a written line is committed

Behaviour:
- Reset: req_ready=1, wdata_ready=0, rdata_valid=0, rdata_last=0, rdata=0, wr_done=0, FSM→IDLE, beat and latency counters=0. Memory contents are not reset and are preserved across rst.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT.
- IDLE: req_ready=1 only here. On req_valid&&req_ready, latch address.
  - req_write=0 → RD_WAIT, latency counter loaded with READ_LATENCY.
  - req_write=1 → WR_BURST, beat counter=0.
- RD_WAIT: decrement counter each cycle. On the final cycle, copy the full addressed line into the line buffer and go to RD_BURST. First rdata_valid is at accept cycle T + READ_LATENCY + 1.
- RD_BURST: rdata = buffer word[beat], word 0 (lowest address) first.
  - Each beat advances on rdata_valid&&rdata_ready.
  - rdata and rdata_last stay stable while stalled; no beat is dropped or repeated.
  - rdata_last=1 on beat 3.
  - After the last handshake: rdata_valid=0 and FSM→IDLE. The next request can be accepted on the following cycle.
- WR_BURST: wdata_ready=1. Each wdata_valid&&wdata_ready stores wdata into staging word[beat]. After beat 3 → WR_WAIT, counter loaded with WRITE_LATENCY. wdata_valid outside WR_BURST is ignored.
- WR_WAIT: on the final count cycle, write all four staging words to the array in one cycle. Pulse wr_done for exactly that cycle, then FSM→IDLE.
- Read-after-write: a read accepted after wr_done returns the new data.
- Addressing: array word index = {req_line_addr, beat[1:0]}. All 4096 lines are valid; there is no out-of-range case.
- Reset mid-operation: the transfer is aborted and staging/line buffers are discarded. A write interrupted before commit leaves the array unchanged. A read in progress produces no further beats.

Optional Feature:
- Macro MEM_ACCESS_CNT_EN. When defined, adds outputs rd_count and wr_count, each 32 bits, reset to 0.
  - rd_count increments on the last read beat handshake.
  - wr_count increments with wr_done.
  - Both wrap at 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Add to package memory_sub_system_param:
  - BEATS_PER_LINE = CACHE_LINE_SIZE*8/WORD_SIZE (4)
  - LINE_ADDR_LENGTH = TAG_LENGTH+INDEX_LENGTH (12)
  - MEM_WORDS = MEMORY_SIZE*8/WORD_SIZE
  - typedefs word_t, line_addr_t, line_t (array of BEATS_PER_LINE word_t)
  - enum mem_resp_state_t
- One sub-module, main_mem_array: single-port storage with one-cycle full-line read and full-line write.

Test Plan:
- Reset, then idle → req_ready=1, rdata_valid=0, wdata_ready=0, wr_done=0.
- Write line 0x03A with 0x11111111, 0x22222222, 0x33333333, 0x44444444 → wr_done 5 cycles after beat 3 accept. Then read 0x03A → first rdata_valid exactly 9 cycles after accept; beats arrive in that order; rdata_last only on 0x44444444.
- During that read, hold rdata_ready=0 for 3 cycles at beat 1 → rdata stays 0x22222222 and rdata_valid stays 1 throughout; the next beat after release is 0x33333333.
- Write distinct data to lines 0x000 and 0xFFF, read both back → each returns its own data, no aliasing.
- Assert rst after 2 write beats to line 0x010 holding prior data 0xA5A5A5A5 ×4 → no wr_done; a subsequent read returns 0xA5A5A5A5 ×4.
- With MEM_ACCESS_CNT_EN, perform 3 reads and 2 writes → rd_count=3, wr_count=2; after rst both read 0.

Source files
------------

// File: rtl/memory_sub_system_param.sv
// Shared memory-subsystem parameters and types for the cache / main-memory pair.
package memory_sub_system_param;

  localparam int MEMORY_SIZE      = 65536;
  localparam int WORD_SIZE        = 32;
  localparam int CACHE_LINE_SIZE  = 16;
  localparam int INDEX_LENGTH     = 8;
  localparam int TAG_LENGTH       = 4;

  localparam int BEATS_PER_LINE   = CACHE_LINE_SIZE * 8 / WORD_SIZE;
  localparam int LINE_ADDR_LENGTH = TAG_LENGTH + INDEX_LENGTH;
  localparam int MEM_WORDS        = MEMORY_SIZE * 8 / WORD_SIZE;
  localparam int MEM_LINES        = MEM_WORDS / BEATS_PER_LINE;
  localparam int BEAT_W           = $clog2(BEATS_PER_LINE);
  localparam int LINE_W           = BEATS_PER_LINE * WORD_SIZE;

  typedef logic [WORD_SIZE-1:0]        word_t;
  typedef logic [LINE_ADDR_LENGTH-1:0] line_addr_t;
  typedef word_t [BEATS_PER_LINE-1:0]  line_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_WAIT
  } mem_resp_state_t;

endpackage

// File: rtl/main_mem_array.sv
// Line-wide single-port storage: asynchronous full-line read, one-cycle full-line write.
module main_mem_array
  import memory_sub_system_param::*;
(
  input  logic                        clk_i,
  input  logic                        wr_en_i,
  input  logic [LINE_ADDR_LENGTH-1:0] addr_i,
  input  logic [LINE_W-1:0]           wr_line_i,
  output logic [LINE_W-1:0]           rd_line_o
);

  // Deliberately no reset: contents survive rst.
  logic [LINE_W-1:0] mem_q [MEM_LINES];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_line_i;
    end
  end

  assign rd_line_o = mem_q[addr_i];

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder serving cache line refills and write-backs as 4-beat bursts.
// Optional MEM_ACCESS_CNT_EN adds rd_count / wr_count access counters.
module main_mem_responder
  import memory_sub_system_param::*;
#(
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [LINE_ADDR_LENGTH-1:0] req_line_addr,
  input  logic                        wdata_valid,
  input  logic [WORD_SIZE-1:0]        wdata,
  output logic                        wdata_ready,
  output logic                        rdata_valid,
  output logic [WORD_SIZE-1:0]        rdata,
  output logic                        rdata_last,
  input  logic                        rdata_ready,
  output logic                        wr_done
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]                 rd_count,
  output logic [31:0]                 wr_count
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  mem_resp_state_t   state_q;
  line_addr_t        addr_q;
  logic [7:0]        cnt_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_nxt;
  line_t             line_buf_q;
  line_t             stage_q;
  line_t             rd_line;
  logic              req_ready_q;
  logic              wdata_ready_q;
  logic              rdata_valid_q;
  logic              rdata_last_q;
  word_t             rdata_q;
  logic              wr_done_q;
  logic              commit;
  logic              rd_last_hs;

  assign beat_nxt   = beat_q + BEAT_ONE;
  // Gated by rst so an abort on the commit cycle leaves the array untouched.
  assign commit     = (state_q == WR_WAIT) && (cnt_q == 8'd1) && !rst;
  assign rd_last_hs = (state_q == RD_BURST) && rdata_ready && (beat_q == LAST_BEAT);

  main_mem_array u_array (
    .clk_i     (clk),
    .wr_en_i   (commit),
    .addr_i    (addr_q),
    .wr_line_i (stage_q),
    .rd_line_o (rd_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      beat_q        <= '0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      rdata_q       <= '0;
      wr_done_q     <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_line_addr;
            req_ready_q <= 1'b0;
            beat_q      <= '0;
            if (req_write) begin
              state_q       <= WR_BURST;
              wdata_ready_q <= 1'b1;
            end else begin
              state_q <= RD_WAIT;
              cnt_q   <= 8'(READ_LATENCY);
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == 8'd1) begin
            line_buf_q    <= rd_line;
            rdata_q       <= rd_line[0];
            rdata_last_q  <= (LAST_BEAT == '0);
            rdata_valid_q <= 1'b1;
            cnt_q         <= 8'd0;
            state_q       <= RD_BURST;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RD_BURST: begin
          if (rdata_ready) begin
            if (beat_q == LAST_BEAT) begin
              rdata_valid_q <= 1'b0;
              rdata_last_q  <= 1'b0;
              req_ready_q   <= 1'b1;
              beat_q        <= '0;
              state_q       <= IDLE;
            end else begin
              beat_q       <= beat_nxt;
              rdata_q      <= line_buf_q[beat_nxt];
              rdata_last_q <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        WR_BURST: begin
          if (wdata_valid) begin
            stage_q[beat_q] <= wdata;
            if (beat_q == LAST_BEAT) begin
              wdata_ready_q <= 1'b0;
              beat_q        <= '0;
              cnt_q         <= 8'(WRITE_LATENCY);
              state_q       <= WR_WAIT;
            end else begin
              beat_q <= beat_nxt;
            end
          end
        end
        WR_WAIT: begin
          if (cnt_q == 8'd1) begin
            wr_done_q   <= 1'b1;
            req_ready_q <= 1'b1;
            cnt_q       <= 8'd0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q       <= IDLE;
          req_ready_q   <= 1'b1;
          wdata_ready_q <= 1'b0;
          rdata_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rdata_last_q;
  assign wr_done     = wr_done_q;

`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  assign rd_count_d = rd_last_hs ? rd_count_q + 32'd1 : rd_count_q;
  assign wr_count_d = commit ? wr_count_q + 32'd1 : wr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  logic unused_rd_last_hs;
  assign unused_rd_last_hs = rd_last_hs;
`endif

endmodule
